// File: rtl/bicubic_window_reader_if.sv
// Request, ROM and window-output signals of the bicubic window reader.
// slave = the reader itself, master = the requester / ROM / consumer side.
interface bicubic_window_reader_if #(
   parameter int unsigned PIX_W   = 8,
   parameter int unsigned COORD_W = 7,
   parameter int unsigned ADDR_W  = 14
);
   logic                 req_valid;
   logic                 req_ready;
   logic [COORD_W-1:0]   req_x;
   logic [COORD_W-1:0]   req_y;
   logic                 req_dir;
   logic                 rom_cen;
   logic [ADDR_W-1:0]    rom_a;
   logic [PIX_W-1:0]     rom_q;
   logic                 win_valid;
   logic                 win_ready;
   logic [4*PIX_W-1:0]   win_data;

   modport master (
      output req_valid, req_x, req_y, req_dir, rom_q, win_ready,
      input  req_ready, rom_cen, rom_a, win_valid, win_data
   );

   modport slave (
      input  req_valid, req_x, req_y, req_dir, rom_q, win_ready,
      output req_ready, rom_cen, rom_a, win_valid, win_data
   );
endinterface

// File: rtl/bicubic_window_reader.sv
// Fetches the 4-tap window (c-1..c+2, border-clamped) for one bicubic step from
// a 1-cycle-latency ROM and presents it as a packed word via valid/ready.
module bicubic_window_reader #(
   parameter int unsigned PIX_W   = 8,
   parameter int unsigned COORD_W = 7,
   parameter int unsigned ADDR_W  = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] img_w,
   input  logic [COORD_W-1:0] img_h,
   bicubic_window_reader_if.slave bus
);

   localparam int unsigned SW = COORD_W + 2;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

   state_t                    state_q, state_d;
   logic [1:0]                idx_q;
   logic [COORD_W-1:0]        x_q, y_q, w_q, h_q;
   logic                      dir_q;
   logic [3:0][PIX_W-1:0]     slot_q;
   logic [ADDR_W-1:0]         a_hold_q;

   logic [COORD_W-1:0]        axis_c, axis_dim, other_c, other_dim;
   logic [COORD_W-1:0]        tap_c, other_cl, x_f, y_f;
   logic signed [SW-1:0]      tap_pos, axis_max;
   logic [2*COORD_W-1:0]      prod;
   logic [ADDR_W-1:0]         fetch_addr;

   // Tap address for the current fetch index, from the latched request.
   always_comb begin
      axis_c    = dir_q ? y_q : x_q;
      axis_dim  = dir_q ? h_q : w_q;
      other_c   = dir_q ? x_q : y_q;
      other_dim = dir_q ? w_q : h_q;
      tap_pos   = $signed({2'b00, axis_c} + {{COORD_W{1'b0}}, idx_q} - SW'(1));
      axis_max  = $signed({2'b00, axis_dim - COORD_W'(1)});
      if (tap_pos[SW-1])
         tap_c = '0;
      else if (tap_pos > axis_max)
         tap_c = axis_dim - COORD_W'(1);
      else
         tap_c = tap_pos[COORD_W-1:0];
      other_cl   = (other_c > other_dim - COORD_W'(1)) ? other_dim - COORD_W'(1) : other_c;
      x_f        = dir_q ? other_cl : tap_c;
      y_f        = dir_q ? tap_c : other_cl;
      prod       = {{COORD_W{1'b0}}, y_f} * {{COORD_W{1'b0}}, w_q};
      fetch_addr = ADDR_W'(prod) + ADDR_W'(x_f);
   end

   always_comb begin
      state_d       = state_q;
      bus.req_ready = (state_q == IDLE) && !rst;
      bus.rom_cen   = (state_q != FETCH);
      bus.rom_a     = (state_q == FETCH) ? fetch_addr : a_hold_q;
      bus.win_valid = (state_q == HOLD);
      bus.win_data  = slot_q;
      unique case (state_q)
         IDLE:  if (bus.req_valid) state_d = FETCH;
         FETCH: if (idx_q == 2'd3) state_d = DRAIN;
         DRAIN: state_d = HOLD;
         HOLD:  if (bus.win_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         w_q      <= '0;
         h_q      <= '0;
         dir_q    <= 1'b0;
         slot_q   <= '0;
         a_hold_q <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  x_q   <= bus.req_x;
                  y_q   <= bus.req_y;
                  dir_q <= bus.req_dir;
                  w_q   <= img_w;
                  h_q   <= img_h;
                  idx_q <= '0;
               end
            end
            FETCH: begin
               idx_q    <= idx_q + 2'd1;
               a_hold_q <= fetch_addr;
               // ROM data lags the address by one cycle: slot k fills while tap k+1 is issued.
               if (idx_q != 2'd0)
                  slot_q[idx_q - 2'd1] <= bus.rom_q;
            end
            DRAIN: slot_q[3] <= bus.rom_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bicubic_window_reader.sv
// Self-checking bench for bicubic_window_reader: directed table, reset/backpressure
// sequences and randomized requests against a clamp-and-index reference model.
module tb_bicubic_window_reader;

   logic       clk;
   logic       rst;
   logic [6:0] img_w, img_h;
   int         n_cmp = 0;
   int         n_bad = 0;

   bicubic_window_reader_if #(.PIX_W(8), .COORD_W(7), .ADDR_W(14)) bus ();

   bicubic_window_reader #(.PIX_W(8), .COORD_W(7), .ADDR_W(14)) dut (
      .clk   (clk),
      .rst   (rst),
      .img_w (img_w),
      .img_h (img_h),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // ROM: rom[a] = a[7:0], data one cycle after the address is sampled.
   always @(posedge clk)
      if (!bus.rom_cen) bus.rom_q <= bus.rom_a[7:0];

   typedef struct {
      logic [6:0]        x, y;
      logic              dir;
      logic [6:0]        w, h;
      logic [3:0][13:0]  a;
      logic [31:0]       d;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic int model_addr(input int x, input int y, input int dir,
                                     input int w, input int h, input int k);
      int tx = x;
      int ty = y;
      if (dir == 0) tx = x + k - 1;
      else          ty = y + k - 1;
      tx = clampi(tx, 0, w - 1);
      ty = clampi(ty, 0, h - 1);
      return ty * w + tx;
   endfunction

   task automatic model(input int x, input int y, input int dir, input int w, input int h,
                        output logic [3:0][13:0] ea, output logic [31:0] ed);
      for (int k = 0; k < 4; k++) begin
         ea[k] = 14'(model_addr(x, y, dir, w, h, k));
         ed[k*8 +: 8] = ea[k][7:0];
      end
   endtask

   // Issue one request from the negedge region and follow it to window acceptance.
   task automatic run(input logic [6:0] x, input logic [6:0] y, input logic dir,
                      input logic [6:0] w, input logic [6:0] h,
                      input logic [3:0][13:0] ea, input logic [31:0] ed,
                      input int hold, input string tag);
      bus.req_x     = x;
      bus.req_y     = y;
      bus.req_dir   = dir;
      img_w         = w;
      img_h         = h;
      bus.req_valid = 1'b1;
      bus.win_ready = 1'b0;
      chk({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_x     = 7'($urandom);
      bus.req_y     = 7'($urandom);
      bus.req_dir   = 1'($urandom);
      img_w         = 7'($urandom_range(1, 100));
      img_h         = 7'($urandom_range(1, 100));
      for (int k = 0; k < 4; k++) begin
         bus.win_ready = 1'($urandom);
         chk({tag, " rom_cen fetch"}, 32'(bus.rom_cen), 32'd0);
         chk({tag, " rom_a"}, 32'(bus.rom_a), 32'(ea[k]));
         @(negedge clk);
      end
      chk({tag, " rom_cen drain"}, 32'(bus.rom_cen), 32'd1);
      chk({tag, " win_valid drain"}, 32'(bus.win_valid), 32'd0);
      bus.win_ready = 1'b0;
      @(negedge clk);
      chk({tag, " win_valid"}, 32'(bus.win_valid), 32'd1);
      chk({tag, " win_data"}, bus.win_data, ed);
      chk({tag, " rom_cen hold"}, 32'(bus.rom_cen), 32'd1);
      chk({tag, " req_ready hold"}, 32'(bus.req_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, " win_valid held"}, 32'(bus.win_valid), 32'd1);
         chk({tag, " win_data held"}, bus.win_data, ed);
         chk({tag, " rom_cen held"}, 32'(bus.rom_cen), 32'd1);
         chk({tag, " req_ready held"}, 32'(bus.req_ready), 32'd0);
      end
      bus.win_ready = 1'b1;
      @(negedge clk);
      bus.win_ready = 1'b0;
      chk({tag, " win_valid after accept"}, 32'(bus.win_valid), 32'd0);
      chk({tag, " req_ready after accept"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      logic [3:0][13:0] ea;
      logic [31:0]      ed;
      int               w, h;

      tbl[0] = '{x:1, y:2, dir:0, w:4, h:4, a:{14'd11, 14'd10, 14'd9,  14'd8},  d:32'h0B0A0908};
      tbl[1] = '{x:0, y:2, dir:0, w:4, h:4, a:{14'd10, 14'd9,  14'd8,  14'd8},  d:32'h0A090808};
      tbl[2] = '{x:3, y:2, dir:0, w:4, h:4, a:{14'd11, 14'd11, 14'd11, 14'd10}, d:32'h0B0B0B0A};
      tbl[3] = '{x:1, y:3, dir:1, w:4, h:4, a:{14'd13, 14'd13, 14'd13, 14'd9},  d:32'h0D0D0D09};
      tbl[4] = '{x:1, y:0, dir:1, w:4, h:4, a:{14'd9,  14'd5,  14'd1,  14'd1},  d:32'h09050101};
      tbl[5] = '{x:2, y:9, dir:0, w:4, h:4, a:{14'd15, 14'd15, 14'd14, 14'd13}, d:32'h0F0F0E0D};
      tbl[6] = '{x:0, y:2, dir:0, w:1, h:4, a:{14'd2,  14'd2,  14'd2,  14'd2},  d:32'h02020202};
      tbl[7] = '{x:2, y:0, dir:1, w:4, h:1, a:{14'd2,  14'd2,  14'd2,  14'd2},  d:32'h02020202};

      clk           = 1'b0;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_x     = '0;
      bus.req_y     = '0;
      bus.req_dir   = 1'b0;
      bus.win_ready = 1'b0;
      img_w         = 7'd4;
      img_h         = 7'd4;

      repeat (2) @(negedge clk);
      chk("reset req_ready", 32'(bus.req_ready), 32'd0);
      chk("reset rom_cen", 32'(bus.rom_cen), 32'd1);
      chk("reset rom_a", 32'(bus.rom_a), 32'd0);
      chk("reset win_valid", 32'(bus.win_valid), 32'd0);
      chk("reset win_data", bus.win_data, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset req_ready", 32'(bus.req_ready), 32'd1);

      for (int i = 0; i < 8; i++)
         run(tbl[i].x, tbl[i].y, tbl[i].dir, tbl[i].w, tbl[i].h, tbl[i].a, tbl[i].d,
             (i == 0) ? 3 : i % 3, $sformatf("vec%0d", i));

      // Reset pulsed in the second fetch cycle must abort without a window.
      img_w         = 7'd4;
      img_h         = 7'd4;
      bus.req_x     = 7'd1;
      bus.req_y     = 7'd2;
      bus.req_dir   = 1'b0;
      bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("rstfetch rom_a c1", 32'(bus.rom_a), 32'd8);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstfetch rom_cen", 32'(bus.rom_cen), 32'd1);
      chk("rstfetch win_valid", 32'(bus.win_valid), 32'd0);
      chk("rstfetch win_data", bus.win_data, 32'd0);
      chk("rstfetch req_ready in rst", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("rstfetch req_ready after", 32'(bus.req_ready), 32'd1);
      model(2, 0, 0, 4, 4, ea, ed);
      run(7'd2, 7'd0, 1'b0, 7'd4, 7'd4, ea, ed, 1, "after-reset");
      @(negedge clk);
      chk("after-reset idle win_valid", 32'(bus.win_valid), 32'd0);

      for (int t = 0; t < 40; t++) begin
         logic [6:0] rx, ry;
         logic       rd;
         w  = $urandom_range(1, 100);
         h  = $urandom_range(1, 100);
         rx = 7'($urandom_range(0, w + 2));
         ry = 7'($urandom_range(0, h + 2));
         rd = 1'($urandom);
         model(int'(rx), int'(ry), int'(rd), w, h, ea, ed);
         run(rx, ry, rd, 7'(w), 7'(h), ea, ed, $urandom_range(0, 3), $sformatf("rand%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
